// File: rtl/dmem_resp_pkg.sv
// Shared types and helpers for dmem_responder and its arbiter.
// Optional macro DMEM_RESPONDER_RR_EN selects round-robin arbitration.
package dmem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } state_e;

  localparam int NUM_CONSUMERS_DEF = 8;
  localparam int IDX_BITS          = $clog2(NUM_CONSUMERS_DEF);

  // Index width that stays legal for a single-channel build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// Combinational channel picker: round-robin from i_ptr when DMEM_RESPONDER_RR_EN
// is defined, otherwise fixed priority with the lowest index winning.
module dmem_rr_arbiter
  import dmem_resp_pkg::*;
#(
  parameter int N     = NUM_CONSUMERS_DEF,
  parameter int IDX_W = IDX_BITS
) (
  input  logic [N-1:0]     i_req,
`ifdef DMEM_RESPONDER_RR_EN
  input  logic [IDX_W-1:0] i_ptr,
`endif
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx
);

  logic w_found;
`ifdef DMEM_RESPONDER_RR_EN
  localparam int POS_W = IDX_W + 1;
  logic [POS_W-1:0] w_pos;
`endif

  // NOTE: every variable written here gets a default first, so no path leaves a latch.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
`ifdef DMEM_RESPONDER_RR_EN
    w_pos   = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = {1'b0, i_ptr} + POS_W'(k);
      if (w_pos >= POS_W'(N)) w_pos = w_pos - POS_W'(N);
      if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
        w_found                      = 1'b1;
        o_grant[w_pos[IDX_W-1:0]] = 1'b1;
        o_idx                        = w_pos[IDX_W-1:0];
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[k]) begin
        w_found    = 1'b1;
        o_grant[k] = 1'b1;
        o_idx      = IDX_W'(k);
      end
    end
`endif
  end

endmodule

// File: rtl/dmem_responder.sv
// Arbitrates per-thread LSU read/write channels onto one data-memory port, one
// transaction in flight. DMEM_RESPONDER_RR_EN enables round-robin arbitration.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic                                     mem_read_valid,
  output logic [ADDR_BITS-1:0]                     mem_read_address,
  input  logic                                     mem_read_ready,
  input  logic [DATA_BITS-1:0]                     mem_read_data,
  output logic                                     mem_write_valid,
  output logic [ADDR_BITS-1:0]                     mem_write_address,
  output logic [DATA_BITS-1:0]                     mem_write_data,
  input  logic                                     mem_write_ready
);

  localparam int IDX_W = idx_width(NUM_CONSUMERS);

  state_e                                  r_state,    w_state_nxt;
  logic [IDX_W-1:0]                        r_idx,      w_idx_nxt;
  logic [ADDR_BITS-1:0]                    r_addr,     w_addr_nxt;
  logic [DATA_BITS-1:0]                    r_data,     w_data_nxt;
  logic                                    r_rd_valid, w_rd_valid_nxt;
  logic                                    r_wr_valid, w_wr_valid_nxt;
  logic [NUM_CONSUMERS-1:0]                r_rd_ready, w_rd_ready_nxt;
  logic [NUM_CONSUMERS-1:0]                r_wr_ready, w_wr_ready_nxt;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] r_rd_data,  w_rd_data_nxt;
`ifdef DMEM_RESPONDER_RR_EN
  logic [IDX_W-1:0]                        r_ptr,      w_ptr_nxt;
`endif

  logic [NUM_CONSUMERS-1:0] w_req;
  logic [NUM_CONSUMERS-1:0] w_grant;
  logic [IDX_W-1:0]         w_grant_idx;
  logic                     w_pick_read;
  logic                     w_relay_valid;

  // Channels still holding ready from the last transaction are not eligible.
  assign w_req         = (consumer_read_valid | consumer_write_valid) & ~(r_rd_ready | r_wr_ready);
  assign w_pick_read   = |(w_grant & consumer_read_valid);
  assign w_relay_valid = r_rd_ready[r_idx] ? consumer_read_valid[r_idx]
                                           : consumer_write_valid[r_idx];

  dmem_rr_arbiter #(
    .N     (NUM_CONSUMERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_req   (w_req),
`ifdef DMEM_RESPONDER_RR_EN
    .i_ptr   (r_ptr),
`endif
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_rd_valid_nxt = r_rd_valid;
    w_wr_valid_nxt = r_wr_valid;
    w_rd_ready_nxt = r_rd_ready;
    w_wr_ready_nxt = r_wr_ready;
    w_rd_data_nxt  = r_rd_data;
`ifdef DMEM_RESPONDER_RR_EN
    w_ptr_nxt      = r_ptr;
`endif
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_idx_nxt   = w_grant_idx;
          w_addr_nxt  = w_pick_read ? consumer_read_address[w_grant_idx]
                                    : consumer_write_address[w_grant_idx];
          w_data_nxt  = consumer_write_data[w_grant_idx];
          w_state_nxt = w_pick_read ? READ_WAIT : WRITE_WAIT;
        end
      end
      // The downstream request goes out one cycle after the latch.
      READ_WAIT: begin
        if (r_rd_valid && mem_read_ready) begin
          w_rd_valid_nxt        = 1'b0;
          w_rd_data_nxt[r_idx]  = mem_read_data;
          w_rd_ready_nxt[r_idx] = 1'b1;
          w_state_nxt           = RELAY;
        end else begin
          w_rd_valid_nxt = 1'b1;
        end
      end
      WRITE_WAIT: begin
        if (r_wr_valid && mem_write_ready) begin
          w_wr_valid_nxt        = 1'b0;
          w_wr_ready_nxt[r_idx] = 1'b1;
          w_state_nxt           = RELAY;
        end else begin
          w_wr_valid_nxt = 1'b1;
        end
      end
      RELAY: begin
        if (!w_relay_valid) begin
          w_rd_ready_nxt[r_idx] = 1'b0;
          w_wr_ready_nxt[r_idx] = 1'b0;
`ifdef DMEM_RESPONDER_RR_EN
          w_ptr_nxt = (r_idx == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : r_idx + 1'b1;
`endif
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the read-data storage is reset too, since it drives outputs that must read 0 after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;
      r_rd_ready <= '0;
      r_wr_ready <= '0;
      r_rd_data  <= '0;
`ifdef DMEM_RESPONDER_RR_EN
      r_ptr      <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_wr_valid <= w_wr_valid_nxt;
      r_rd_ready <= w_rd_ready_nxt;
      r_wr_ready <= w_wr_ready_nxt;
      r_rd_data  <= w_rd_data_nxt;
`ifdef DMEM_RESPONDER_RR_EN
      r_ptr      <= w_ptr_nxt;
`endif
    end
  end

  assign consumer_read_ready  = r_rd_ready;
  assign consumer_read_data   = r_rd_data;
  assign consumer_write_ready = r_wr_ready;
  assign mem_read_valid       = r_rd_valid;
  assign mem_read_address     = r_addr;
  assign mem_write_valid      = r_wr_valid;
  assign mem_write_address    = r_addr;
  assign mem_write_data       = r_data;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed protocol cases followed by
// randomized multi-channel rounds checked against a shadow memory model.
module tb_dmem_responder;

  localparam int N = 8;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]      consumer_read_valid, consumer_read_ready;
  logic [N-1:0]      consumer_write_valid, consumer_write_ready;
  logic [N-1:0][7:0] consumer_read_address, consumer_read_data;
  logic [N-1:0][7:0] consumer_write_address, consumer_write_data;
  logic              mem_read_valid, mem_write_valid;
  logic              mem_read_ready  = 1'b0;
  logic              mem_write_ready = 1'b0;
  logic [7:0]        mem_read_address, mem_write_address, mem_write_data;
  logic [7:0]        mem_read_data = 8'h00;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(N)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (consumer_read_valid),
    .consumer_read_address  (consumer_read_address),
    .consumer_read_ready    (consumer_read_ready),
    .consumer_read_data     (consumer_read_data),
    .consumer_write_valid   (consumer_write_valid),
    .consumer_write_address (consumer_write_address),
    .consumer_write_data    (consumer_write_data),
    .consumer_write_ready   (consumer_write_ready),
    .mem_read_valid         (mem_read_valid),
    .mem_read_address       (mem_read_address),
    .mem_read_ready         (mem_read_ready),
    .mem_read_data          (mem_read_data),
    .mem_write_valid        (mem_write_valid),
    .mem_write_address      (mem_write_address),
    .mem_write_data         (mem_write_data),
    .mem_write_ready        (mem_write_ready)
  );

  typedef struct {int ch; bit wr; logic [7:0] data;} comp_t;

  comp_t      comps[$];
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rd  [N];
  logic [N-1:0][7:0] exp_rdata;
  int         rd_reraise[N];
  int         mem_lat = 0;
  int         rd_cnt  = -1;
  int         wr_cnt  = -1;
  int         checks  = 0;
  int         errors  = 0;
  int         exp_order[4];
  comp_t      c;

  // Memory device: mem_lat idle cycles, then a one-cycle ready pulse.
  always @(negedge clk) begin
    mem_read_ready  = 1'b0;
    mem_write_ready = 1'b0;
    mem_read_data   = 8'($urandom);
    if (reset) begin
      for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'hB7;
      rd_cnt = -1;
      wr_cnt = -1;
    end else begin
      if (mem_read_valid) begin
        if (rd_cnt < 0) rd_cnt = mem_lat;
        if (rd_cnt == 0) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem[mem_read_address];
          rd_cnt         = -1;
        end else rd_cnt--;
      end else rd_cnt = -1;
      if (mem_write_valid) begin
        if (wr_cnt < 0) wr_cnt = mem_lat;
        if (wr_cnt == 0) begin
          mem_write_ready         = 1'b1;
          mem[mem_write_address]  = mem_write_data;
          wr_cnt                  = -1;
        end else wr_cnt--;
      end else wr_cnt = -1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ctrl_vec();
    return 64'({consumer_read_ready, consumer_write_ready, mem_read_valid, mem_write_valid,
                mem_read_address, mem_write_address, mem_write_data});
  endfunction

  function automatic void ref_init();
    for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a) ^ 8'hB7;
  endfunction

  // One cycle of the consumer side: drop valid on ready, optionally re-raise.
  task automatic tick();
    @(negedge clk);
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        if (consumer_read_valid[i] && consumer_read_ready[i]) begin
          comps.push_back('{i, 1'b0, consumer_read_data[i]});
          consumer_read_valid[i] = 1'b0;
        end else if (!consumer_read_valid[i] && !consumer_read_ready[i] && rd_reraise[i] > 0) begin
          rd_reraise[i]--;
          consumer_read_valid[i] = 1'b1;
        end
        if (consumer_write_valid[i] && consumer_write_ready[i]) begin
          comps.push_back('{i, 1'b1, 8'h00});
          consumer_write_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_comps(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (comps.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(comps.size()), 64'(n));
  endtask

  task automatic expect_read(input string tag, input int ch, input logic [7:0] data);
    c = comps.pop_front();
    check({tag, "_ch"},   64'(c.ch), 64'(ch));
    check({tag, "_kind"}, 64'(c.wr), 64'(0));
    check({tag, "_data"}, 64'(c.data), 64'(data));
    exp_rdata[ch] = data;
  endtask

  task automatic expect_write(input string tag, input int ch);
    c = comps.pop_front();
    check({tag, "_ch"},   64'(c.ch), 64'(ch));
    check({tag, "_kind"}, 64'(c.wr), 64'(1));
  endtask

  initial begin
`ifdef DMEM_RESPONDER_RR_EN
    exp_order = '{1, 2, 5, 1};
`else
    exp_order = '{1, 1, 2, 5};
`endif
    reset                  = 1'b1;
    consumer_read_valid    = '0;
    consumer_write_valid   = '0;
    consumer_read_address  = '0;
    consumer_write_address = '0;
    consumer_write_data    = '0;
    exp_rdata              = '0;
    for (int i = 0; i < N; i++) rd_reraise[i] = 0;
    ref_init();

    repeat (3) tick();
    check("reset_ctrl",  ctrl_vec(), 64'd0);
    check("reset_rdata", 64'(consumer_read_data), 64'd0);
    reset = 1'b0;

    repeat (4) tick();
    check("idle_outputs", ctrl_vec(), 64'd0);

    // Single read with exact minimum latency.
    consumer_read_address[0] = 8'h12;
    consumer_read_valid[0]   = 1'b1;
    tick();
    check("rd_memv_edge_n",  64'(mem_read_valid), 64'd0);
    tick();
    check("rd_memv_edge_n1", 64'(mem_read_valid), 64'd1);
    check("rd_mem_addr",     64'(mem_read_address), 64'h12);
    tick();
    check("rd_ready_edge_n2", 64'(consumer_read_ready[0]), 64'd1);
    check("rd_data_edge_n2",  64'(consumer_read_data[0]), 64'hA5);
    tick();
    check("rd_ready_dropped", 64'(consumer_read_ready[0]), 64'd0);
    check("rd_data_held",     64'(consumer_read_data[0]), 64'hA5);
    check("rd_comp_count",    64'(comps.size()), 64'd1);
    expect_read("rd_single", 0, 8'hA5);

    // Single write on channel 3.
    consumer_write_address[3] = 8'h40;
    consumer_write_data[3]    = 8'h7C;
    consumer_write_valid[3]   = 1'b1;
    for (int k = 0; k < 10 && !mem_write_valid; k++) tick();
    check("wr_memv_seen", 64'(mem_write_valid), 64'd1);
    check("wr_mem_addr",  64'(mem_write_address), 64'h40);
    check("wr_mem_data",  64'(mem_write_data), 64'h7C);
    wait_comps(1, 20, "wr_done");
    expect_write("wr_single", 3);
    check("wr_mem_content", 64'(mem[8'h40]), 64'h7C);
    ref_mem[8'h40] = 8'h7C;
    tick();
    check("wr_ready_dropped", 64'(consumer_write_ready), 64'd0);

    // Contention on channels 1, 2, 5 with channel 1 re-raising once.
    mem_lat = 1;
    consumer_read_address[1] = 8'h21;
    consumer_read_address[2] = 8'h42;
    consumer_read_address[5] = 8'hA3;
    rd_reraise[1] = 1;
    consumer_read_valid[1] = 1'b1;
    consumer_read_valid[2] = 1'b1;
    consumer_read_valid[5] = 1'b1;
    wait_comps(4, 200, "cont_done");
    for (int k = 0; k < 4; k++)
      expect_read("cont", exp_order[k], ref_mem[consumer_read_address[exp_order[k]]]);

    // Same channel read and write: the read goes first.
    mem_lat = 0;
    consumer_read_address[4]  = 8'h55;
    consumer_write_address[4] = 8'h56;
    consumer_write_data[4]    = 8'h3C;
    consumer_read_valid[4]    = 1'b1;
    consumer_write_valid[4]   = 1'b1;
    wait_comps(2, 40, "rw_done");
    expect_read("rw_first", 4, ref_mem[8'h55]);
    expect_write("rw_second", 4);
    check("rw_mem_content", 64'(mem[8'h56]), 64'h3C);
    ref_mem[8'h56] = 8'h3C;
    repeat (2) tick();

    // Reset while a read waits on a slow memory.
    mem_lat = 6;
    consumer_read_address[0] = 8'h10;
    consumer_read_valid[0]   = 1'b1;
    for (int k = 0; k < 10 && !mem_read_valid; k++) tick();
    check("rst_mid_in_read", 64'(mem_read_valid), 64'd1);
    #2;
    reset               = 1'b1;
    consumer_read_valid = '0;
    #1;
    check("rst_mid_ctrl",  ctrl_vec(), 64'd0);
    check("rst_mid_rdata", 64'(consumer_read_data), 64'd0);
    repeat (2) tick();
    comps.delete();
    ref_init();
    exp_rdata = '0;
    reset     = 1'b0;
    mem_lat   = 0;
    consumer_read_address[6] = 8'h66;
    consumer_read_valid[6]   = 1'b1;
    wait_comps(1, 20, "rst_fresh_done");
    expect_read("rst_fresh", 6, 8'h66 ^ 8'hB7);
    repeat (2) tick();

    // Serve ch7 alone (pointer wraps to 0), then ch0 and ch6 together.
    consumer_read_address[7] = 8'hE7;
    consumer_read_valid[7]   = 1'b1;
    wait_comps(1, 20, "wrap_a_done");
    expect_read("wrap_a", 7, ref_mem[8'hE7]);
    repeat (2) tick();
    consumer_read_address[0] = 8'h01;
    consumer_read_address[6] = 8'hC6;
    consumer_read_valid[0]   = 1'b1;
    consumer_read_valid[6]   = 1'b1;
    wait_comps(2, 40, "wrap_b_done");
    expect_read("wrap_b0", 0, ref_mem[8'h01]);
    expect_read("wrap_b1", 6, ref_mem[8'hC6]);
    repeat (2) tick();

    // Randomized rounds; addresses are per-channel so order within a round is free.
    for (int r = 0; r < 30; r++) begin
      logic [N-1:0] rdm, wrm;
      logic [7:0]   addr;
      int           op, n;
      mem_lat = $urandom_range(0, 3);
      rdm = '0;
      wrm = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          op     = $urandom_range(0, 2);
          rdm[i] = (op != 1);
          wrm[i] = (op != 0);
          addr   = {3'(i), 5'($urandom)};
          consumer_read_address[i]  = addr;
          consumer_write_address[i] = addr;
          consumer_write_data[i]    = 8'($urandom);
          exp_rd[i]                 = ref_mem[addr];
        end
      end
      consumer_read_valid  = rdm;
      consumer_write_valid = wrm;
      n = $countones(rdm) + $countones(wrm);
      wait_comps(n, 12 * n + 20, "rnd_done");
      while (comps.size() > 0) begin
        c = comps.pop_front();
        if (!c.wr) begin
          check("rnd_rd_pending", 64'(rdm[c.ch]), 64'd1);
          rdm[c.ch] = 1'b0;
          check("rnd_rd_data", 64'(c.data), 64'(exp_rd[c.ch]));
          exp_rdata[c.ch] = exp_rd[c.ch];
        end else begin
          check("rnd_wr_after_rd", 64'(rdm[c.ch]), 64'd0);
          check("rnd_wr_pending",  64'(wrm[c.ch]), 64'd1);
          wrm[c.ch] = 1'b0;
          addr = consumer_write_address[c.ch];
          check("rnd_wr_mem", 64'(mem[addr]), 64'(consumer_write_data[c.ch]));
          ref_mem[addr] = consumer_write_data[c.ch];
        end
      end
      check("rnd_all_served", 64'({rdm, wrm}), 64'd0);
      repeat (2) tick();
      check("rnd_rdata_hold", 64'(consumer_read_data), 64'(exp_rdata));
      check("rnd_idle_memv", 64'({mem_read_valid, mem_write_valid}), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Responder end of the per-thread data-memory read/write channels driven by the LSUs. It arbitrates NUM_CONSUMERS request channels onto one downstream data-memory port and returns read data or write acknowledgements. One transaction is in flight at a time. It sits between the core's LSU channel bundles and the data memory model or bus.

Parameters:
ADDR_BITS, 8, address width of consumer and memory channels
DATA_BITS, 8, data width of consumer and memory channels
NUM_CONSUMERS, 8, number of LSU channels served (e.g. 2 warps x 4 threads)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
consumer_read_valid  in  [NUM_CONSUMERS]  per-channel read request
consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address
consumer_read_ready  out  [NUM_CONSUMERS]  read data valid / acknowledge
consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  returned read data
consumer_write_valid  in  [NUM_CONSUMERS]  per-channel write request
consumer_write_address  in  [NUM_CONSUMERS][ADDR_BITS]  write address
consumer_write_data  in  [NUM_CONSUMERS][DATA_BITS]  write data
consumer_write_ready  out  [NUM_CONSUMERS]  write acknowledge
mem_read_valid  out  1  downstream read request
mem_read_address  out  ADDR_BITS  downstream read address
mem_read_ready  in  1  downstream read complete (1-cycle pulse)
mem_read_data  in  DATA_BITS  downstream data, valid with mem_read_ready
mem_write_valid  out  1  downstream write request
mem_write_address  out  ADDR_BITS  downstream write address
mem_write_data  out  DATA_BITS  downstream write data
mem_write_ready  in  1  downstream write complete (1-cycle pulse)

Behaviour:
- Clock clk; reset asynchronous, active-high. All outputs are registered.
- Reset values: every output 0; state IDLE; grant pointer 0; latched index, address and data 0.
- Consumer protocol:
  - Consumer raises valid and holds valid, address and data stable until it sees ready.
  - Consumer then drops valid.
  - Responder holds ready (and read data) high until valid drops, then deasserts ready the following cycle.
- FSM states IDLE, READ_WAIT, WRITE_WAIT, RELAY.
- IDLE:
  - Request vector is read_valid | write_valid, masked by channels whose ready is still high.
  - Arbiter picks one channel; on the picked channel, read beats write when both are valid.
  - Latch index, address and data.
  - Next cycle: mem_read_valid or mem_write_valid = 1 with latched address/data; go READ_WAIT or WRITE_WAIT.
- READ_WAIT:
  - On mem_read_ready: mem_read_valid <= 0, consumer_read_data[idx] <= mem_read_data, consumer_read_ready[idx] <= 1; go RELAY.
  - mem_read_data is sampled only on the ready cycle.
- WRITE_WAIT:
  - On mem_write_ready: mem_write_valid <= 0, consumer_write_ready[idx] <= 1; go RELAY.
- RELAY:
  - When the granted consumer's matching valid is 0: drop its ready, advance pointer to idx+1 (wrap modulo NUM_CONSUMERS), go IDLE.
- Minimum latency with a zero-wait memory: valid seen at edge N; mem valid at N+1; consumer ready at N+2 if mem_*_ready returns at N+1.
- Read data on a non-granted channel holds its last value.
- No requests: stay IDLE; mem valids remain 0.
- Consumer drops valid before ready (protocol violation): the transaction still completes downstream; RELAY exits the first cycle valid is low.
- Reset mid-transaction: immediate return to reset values; the downstream transaction is abandoned, and memory must tolerate valid dropping.
- Pointer wrap: after NUM_CONSUMERS-1, next priority is channel 0.

Optional Feature:
Macro DMEM_RESPONDER_RR_EN.
- Defined: round-robin arbitration. Search starts at the grant pointer, which advances past the last-served channel on each RELAY exit.
- Undefined: fixed priority, lowest index wins. The pointer register is not implemented, and all other timing is identical.

Decomposition:
- Shared package dmem_resp_pkg:
  - state enum typedef (IDLE, READ_WAIT, WRITE_WAIT, RELAY) as 2-bit logic.
  - localparam for index width $clog2(NUM_CONSUMERS).
- One natural sub-module: dmem_rr_arbiter. Inputs are request vector and pointer; outputs are one-hot grant and encoded index. It is combinational, with fixed-priority fallback under the macro.

Test Plan:
- Single read: ch 0 reads addr 0x12, memory returns 0xA5 with 1-cycle latency -> consumer_read_ready[0]=1, consumer_read_data[0]=0xA5; ready drops one cycle after valid drops.
- Single write: ch 3 writes 0x7C to addr 0x40 -> mem_write_address=0x40, mem_write_data=0x7C; consumer_write_ready[3] pulses until valid drops.
- Contention, RR enabled: ch 1, 2, 5 all read at once -> service order 1, 2, 5. A re-asserted ch 1 is served after 5, not before.
- Contention, RR disabled: same stimulus with ch 1 re-raising immediately -> ch 1 is served again before 2.
- Same-channel read+write: ch 4 asserts both -> read completes first, then the write.
- Reset mid-read: assert reset while in READ_WAIT -> all outputs 0 in the same cycle; after release a fresh request on ch 6 completes normally.
